hazard_stall_issue: RTL and testbench

- Consumer end of the hazard-record stream produced by the hazard checker for the 8-bit, 8-instruction, 5-stage RISC.
- Latches a packed 8-instruction program and accepts hazard records {producer, consumer, kind} over a valid/ready handshake.
- Then issues the program in order, one entry per handshake, inserting noop bubbles in front of dependent instructions so the pipeline needs no hazard logic.
- Sits between instruction memory and the IF stage.

---
 rtl/hazard_stall_issue.sv | 176 +++++++++++++++++
 tb/tb_hazard_stall_issue.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_issue.sv
// rtl/hazard_stall_issue.sv - hazard-record consumer that issues the program with noop bubbles
//
// Purpose: latches an 8-instruction program, collects RAW hazard records from
// the hazard checker, then issues the program in order with enough noop
// bubbles in front of dependent instructions that the pipeline needs no
// hazard logic of its own.
//
// Optional feature macro: FORWARD_EN (bubble count from the producer opcode,
// assuming a forwarding pipeline). Undefined: PIPE_GAP - distance rule.
//
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   start           begin a run from IDLE/DONE, latching prog_bits
//   prog_bits       packed program, instruction i at [63-8i -: 8]
//   hz_valid/hz_ready/hz_rec/hz_last   hazard-record stream {prod,cons,kind}
//   out_valid/out_ready                issue-slot handshake
//   issue_instr     instruction, or 8'h00 for a bubble
//   issue_pc        program index of the next real instruction
//   issue_bubble    slot is an inserted bubble
//   done            high in DONE
//   err             sticky illegal-record flag
//   bubble_cnt      bubbles issued this run
module hazard_stall_issue #(
  parameter int N_INSTR  = 8,
  parameter int PIPE_GAP = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [63:0] prog_bits,
  input  logic        hz_valid,
  output logic        hz_ready,
  input  logic [8:0]  hz_rec,
  input  logic        hz_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  issue_instr,
  output logic [2:0]  issue_pc,
  output logic        issue_bubble,
  output logic        done,
  output logic        err,
  output logic [4:0]  bubble_cnt
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    ISSUE   = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [2:0] lastPc = 3'(N_INSTR - 1);
  localparam logic [2:0] gap3   = 3'(PIPE_GAP);

  state_t      state;
  logic [63:0] progReg;
  logic [7:0]  instr [8];
  logic [1:0]  stall [8];
  logic [1:0]  bubLeft;

  logic [2:0]  recProd;
  logic [2:0]  recCons;
  logic [2:0]  recKind;
  logic [2:0]  recDist;
  logic        recNull;
  logic        recGood;
  logic [1:0]  recNeed;
  logic [2:0]  pcNext;

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      instr[i] = progReg[63 - 8*i -: 8];
    end
  end

  assign recProd = hz_rec[8:6];
  assign recCons = hz_rec[5:3];
  assign recKind = hz_rec[2:0];
  assign recDist = recCons - recProd;
  assign recNull = (recKind == 3'b000);
  // Only RAW records whose consumer lies 1..PIPE_GAP-1 slots after the producer
  // can need bubbles; anything further apart is already safe and is flagged.
  assign recGood = (recKind == 3'b001) && (recCons > recProd) && (recDist <= gap3 - 3'd1);
  assign pcNext  = issue_pc + 3'd1;

`ifdef FORWARD_EN
  // With forwarding only a load feeding the very next instruction stalls.
  assign recNeed = ((instr[recProd][7:6] == 2'b11) && (recDist < gap3 - 3'd1)) ? 2'd1 : 2'd0;
`else
  assign recNeed = 2'(gap3 - recDist);
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      progReg      <= '0;
      bubLeft      <= '0;
      hz_ready     <= 1'b0;
      out_valid    <= 1'b0;
      issue_instr  <= '0;
      issue_pc     <= '0;
      issue_bubble <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      bubble_cnt   <= '0;
      for (int i = 0; i < 8; i++) stall[i] <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state      <= COLLECT;
            progReg    <= prog_bits;
            hz_ready   <= 1'b1;
            done       <= 1'b0;
            err        <= 1'b0;
            bubble_cnt <= '0;
            for (int i = 0; i < 8; i++) stall[i] <= '0;
          end
        end

        COLLECT: begin
          if (hz_valid) begin
            if (recGood) begin
              if (recNeed > stall[recCons]) stall[recCons] <= recNeed;
            end else if (!recNull) begin
              err <= 1'b1;
            end
            if (hz_last) begin
              // Instruction 0 can never be a consumer, so its stall entry is
              // always zero and the first slot is always the real instruction.
              state        <= ISSUE;
              hz_ready     <= 1'b0;
              out_valid    <= 1'b1;
              issue_pc     <= 3'd0;
              issue_instr  <= instr[0];
              issue_bubble <= 1'b0;
              bubLeft      <= 2'd0;
            end
          end
        end

        ISSUE: begin
          if (out_ready) begin
            if (bubLeft != 2'd0) begin
              bubLeft    <= bubLeft - 2'd1;
              bubble_cnt <= bubble_cnt + 5'd1;
              if (bubLeft == 2'd1) begin
                issue_instr  <= instr[issue_pc];
                issue_bubble <= 1'b0;
              end
            end else if (issue_pc == lastPc) begin
              state        <= DONE;
              done         <= 1'b1;
              out_valid    <= 1'b0;
              issue_instr  <= '0;
              issue_bubble <= 1'b0;
            end else begin
              issue_pc <= pcNext;
              bubLeft  <= stall[pcNext];
              if (stall[pcNext] != 2'd0) begin
                issue_instr  <= 8'h00;
                issue_bubble <= 1'b1;
              end else begin
                issue_instr  <= instr[pcNext];
                issue_bubble <= 1'b0;
              end
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_stall_issue.sv
// tb/tb_hazard_stall_issue.sv - directed self-checking bench for hazard_stall_issue
module tb_hazard_stall_issue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [63:0] prog_bits;
  logic        hz_valid;
  logic        hz_ready;
  logic [8:0]  hz_rec;
  logic        hz_last;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  issue_instr;
  logic [2:0]  issue_pc;
  logic        issue_bubble;
  logic        done;
  logic        err;
  logic [4:0]  bubble_cnt;

  hazard_stall_issue dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .prog_bits    (prog_bits),
    .hz_valid     (hz_valid),
    .hz_ready     (hz_ready),
    .hz_rec       (hz_rec),
    .hz_last      (hz_last),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .issue_instr  (issue_instr),
    .issue_pc     (issue_pc),
    .issue_bubble (issue_bubble),
    .done         (done),
    .err          (err),
    .bubble_cnt   (bubble_cnt)
  );

  always #5 clk = ~clk;

  localparam logic [63:0] progAdd = 64'h4041424344454647;
  localparam logic [63:0] progLw  = 64'hC841424344454647;

  int errCnt = 0;
  int chkCnt = 0;

  logic [8:0]  recBuf [8];
  int          nRec;
  int          exBub [8];
  logic [11:0] expBeat [64];
  int          nExp;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chkCnt++;
    if (got !== exp) begin
      errCnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [8:0] mkRec(input int prod, input int cons, input logic [2:0] kind);
    return {3'(prod), 3'(cons), kind};
  endfunction

  task automatic clearBub();
    for (int i = 0; i < 8; i++) exBub[i] = 0;
  endtask

  // Expected beat stream from hand-computed per-instruction bubble counts.
  task automatic buildExp(input logic [63:0] prog);
    logic [63:0] p;
    p = prog;
    nExp = 0;
    for (int pc = 0; pc < 8; pc++) begin
      for (int b = 0; b < exBub[pc]; b++) begin
        expBeat[nExp] = {1'b1, 3'(pc), 8'h00};
        nExp++;
      end
      expBeat[nExp] = {1'b0, 3'(pc), p[63 - 8*pc -: 8]};
      nExp++;
    end
  endtask

  task automatic startRun(input logic [63:0] prog);
    prog_bits = prog;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
  endtask

  task automatic sendRecs();
    for (int i = 0; i < nRec; i++) begin
      hz_valid = 1'b1;
      hz_rec   = recBuf[i];
      hz_last  = (i == nRec - 1);
      @(negedge clk);
    end
    hz_valid = 1'b0;
    hz_last  = 1'b0;
    hz_rec   = '0;
  endtask

  task automatic runCase(input string name, input logic [63:0] prog,
                         input int exCnt, input logic exErr);
    int k;
    int cyc;
    buildExp(prog);
    out_ready = 1'b1;
    startRun(prog);
    checkVal({name, ".hz_ready"}, hz_ready, 1);
    checkVal({name, ".err_clr"}, err, 0);
    sendRecs();
    checkVal({name, ".latency"}, out_valid, 1);
    checkVal({name, ".hz_ready_drop"}, hz_ready, 0);
    k   = 0;
    cyc = 0;
    while (!done && cyc < 100) begin
      if (out_valid && out_ready) begin
        if (k < nExp)
          checkVal($sformatf("%s.beat%0d", name, k),
                   {issue_bubble, issue_pc, issue_instr}, expBeat[k]);
        k++;
      end
      @(negedge clk);
      cyc++;
    end
    checkVal({name, ".done"}, done, 1);
    checkVal({name, ".beats"}, k, nExp);
    checkVal({name, ".bubble_cnt"}, bubble_cnt, exCnt);
    checkVal({name, ".err"}, err, exErr);
    checkVal({name, ".valid_drop"}, out_valid, 0);
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    prog_bits = '0;
    hz_valid  = 1'b0;
    hz_rec    = '0;
    hz_last   = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkVal("rst.out_valid", out_valid, 0);
    checkVal("rst.hz_ready", hz_ready, 0);
    checkVal("rst.done", done, 0);
    checkVal("rst.err", err, 0);
    checkVal("rst.bubble_cnt", bubble_cnt, 0);
    checkVal("rst.issue", {issue_bubble, issue_pc, issue_instr}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // No hazards: single null record.
    clearBub();
    recBuf[0] = mkRec(0, 0, 3'b000);
    nRec = 1;
    runCase("nohaz", progAdd, 0, 1'b0);

    // Adjacent RAW: two bubbles before pc1 (one with forwarding? no: add producer).
    clearBub();
`ifndef FORWARD_EN
    exBub[1] = 2;
`endif
    recBuf[0] = mkRec(0, 1, 3'b001);
    nRec = 1;
`ifdef FORWARD_EN
    runCase("raw01", progAdd, 0, 1'b0);
`else
    runCase("raw01", progAdd, 2, 1'b0);
`endif

    // Two producers for pc4: max of requirements, not the sum.
    clearBub();
`ifndef FORWARD_EN
    exBub[4] = 2;
`endif
    recBuf[0] = mkRec(2, 4, 3'b001);
    recBuf[1] = mkRec(3, 4, 3'b001);
    nRec = 2;
`ifdef FORWARD_EN
    runCase("maxrule", progAdd, 0, 1'b0);
`else
    runCase("maxrule", progAdd, 2, 1'b0);
`endif

    // Backward record: ignored, error raised.
    clearBub();
    recBuf[0] = mkRec(5, 4, 3'b001);
    nRec = 1;
    runCase("backward", progAdd, 0, 1'b1);

    // Stall on the first bubble, then reset in the middle of ISSUE.
    out_ready = 1'b1;
    startRun(progAdd);
    checkVal("stall.err_clr", err, 0);
    checkVal("stall.done_clr", done, 0);
    recBuf[0] = mkRec(0, 1, 3'b001);
    nRec = 1;
    sendRecs();
    checkVal("stall.first", {issue_bubble, issue_pc, issue_instr}, {1'b0, 3'd0, 8'h40});
    @(negedge clk);
`ifdef FORWARD_EN
    checkVal("stall.second", {issue_bubble, issue_pc, issue_instr}, {1'b0, 3'd1, 8'h41});
`else
    checkVal("stall.second", {issue_bubble, issue_pc, issue_instr}, {1'b1, 3'd1, 8'h00});
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkVal($sformatf("stall.hold%0d", i),
               {out_valid, issue_bubble, issue_pc, issue_instr}, {1'b1, 1'b1, 3'd1, 8'h00});
    end
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkVal("stall.resume", {issue_bubble, issue_pc, issue_instr}, {1'b0, 3'd1, 8'h41});
    checkVal("stall.cnt", bubble_cnt, 2);
`endif
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checkVal("midrst.out_valid", out_valid, 0);
    checkVal("midrst.done", done, 0);
    checkVal("midrst.bubble_cnt", bubble_cnt, 0);
    checkVal("midrst.hz_ready", hz_ready, 0);
    @(negedge clk);
    checkVal("midrst.idle", out_valid, 0);

    // Distance 3 and unknown kind are errors; valid d=1 record still applies.
    clearBub();
`ifndef FORWARD_EN
    exBub[2] = 2;
`endif
    recBuf[0] = mkRec(0, 3, 3'b001);
    recBuf[1] = mkRec(1, 2, 3'b011);
    recBuf[2] = mkRec(1, 2, 3'b001);
    nRec = 3;
`ifdef FORWARD_EN
    runCase("illegal", progAdd, 0, 1'b1);
`else
    runCase("illegal", progAdd, 2, 1'b1);
`endif

    // Load producer feeding pc1 and pc2.
    clearBub();
    recBuf[0] = mkRec(0, 1, 3'b001);
    recBuf[1] = mkRec(0, 2, 3'b001);
    nRec = 2;
`ifdef FORWARD_EN
    exBub[1] = 1;
    runCase("lw", progLw, 1, 1'b0);
    clearBub();
    runCase("addfwd", progAdd, 0, 1'b0);
`else
    exBub[1] = 2;
    exBub[2] = 1;
    runCase("lw", progLw, 3, 1'b0);
    runCase("addfwd", progAdd, 3, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
    $finish;
  end

endmodule
